// File: rtl/src_fifo.sv
// First-word-fall-through elastic buffer on the DMA AXI-Stream input, {last, data} per entry.
// Optional SRC_FIFO_PKT_CHECK_EN adds a sticky packet-length checker on err_len.
module src_fifo #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [AW:0]       count,
    input  logic [15:0]       expected_len,
    output logic              err_len
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   rp, wp;
    logic [AW:0]     cnt;
    logic            push, pop, clr;

    // Handshakes derive from the registered occupancy only, so no ready/valid loop.
    assign s_ready = (cnt != FULL);
    assign m_valid = (cnt != '0);
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign clr     = rst | flush;
    assign count   = cnt;

    assign {m_last, m_data} = mem[rp];

    always_ff @(posedge clk) begin
        if (clr) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wp] <= {s_last, s_data};
    end

`ifdef SRC_FIFO_PKT_CHECK_EN
    logic [15:0] beat;
    logic [15:0] beat_nxt;
    logic        len_bad;

    assign beat_nxt = beat + 16'd1;
    // Either TLAST came early/late, or the expected final beat arrived without TLAST.
    assign len_bad  = (expected_len != 16'd0) &&
                      (s_last ? (beat_nxt != expected_len) : (beat_nxt == expected_len));

    always_ff @(posedge clk) begin
        if (clr) begin
            beat    <= '0;
            err_len <= 1'b0;
        end else if (push) begin
            beat <= s_last ? 16'd0 : beat_nxt;
            if (len_bad) err_len <= 1'b1;
        end
    end
`else
    logic unused_expected_len;
    assign unused_expected_len = ^expected_len;
    assign err_len             = 1'b0;
`endif

endmodule
